// File: rtl/fpu_lzd_pipe.sv
// Pipelined leading-zero detector for the FMADD normalisation path, with valid/ready and a sideband tag.
// Define FPU_LZD_NORM_EN to also carry the mantissa and produce the pre-normalised out_norm.
module fpu_lzd_pipe #(
  parameter int  WIDTH     = 24,
  parameter int  REG_EVERY = 2,
  parameter int  TAG_W     = 4,
  localparam int LAYERS    = $clog2(WIDTH),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PAD_W = 1 << LAYERS;

  logic             stall;
  logic             in_zero;
  logic [PAD_W-1:0] pad;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign in_zero  = (in_data == '0);

  // Ones below the LSB never win the count for a non-zero word.
  always_comb begin
    pad = '1;
    pad[PAD_W-1 -: WIDTH] = in_data;
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    localparam int NODES  = PAD_W >> (k + 1);
    localparam int PW     = k + 1;
    localparam bit IS_REG = (((k + 1) % REG_EVERY) == 0) && (k != LAYERS - 1);

    logic [NODES-1:0]    c_val, o_val;
    logic [NODES*PW-1:0] c_pos, o_pos;
    logic                i_valid, i_zero, o_valid, o_zero;
    logic [TAG_W-1:0]    i_tag, o_tag;
`ifdef FPU_LZD_NORM_EN
    logic [WIDTH-1:0]    i_data, o_data;
`endif

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < NODES; j++) begin : g_node
        assign c_val[j] = pad[2*j+1] | pad[2*j];
        assign c_pos[j] = ~pad[2*j+1];
      end
      assign i_valid = in_valid;
      assign i_zero  = in_zero;
      assign i_tag   = in_tag;
`ifdef FPU_LZD_NORM_EN
      assign i_data  = in_data;
`endif
    end else begin : g_merge
      for (genvar j = 0; j < NODES; j++) begin : g_node
        logic          vh, vl;
        logic [PW-2:0] ph, pl;
        assign vh = g_layer[k-1].o_val[2*j+1];
        assign vl = g_layer[k-1].o_val[2*j];
        assign ph = g_layer[k-1].o_pos[(2*j+1)*(PW-1) +: PW-1];
        assign pl = g_layer[k-1].o_pos[(2*j)*(PW-1) +: PW-1];
        assign c_val[j]          = vh | vl;
        assign c_pos[j*PW +: PW] = vh ? {1'b0, ph} : {1'b1, pl};
      end
      assign i_valid = g_layer[k-1].o_valid;
      assign i_zero  = g_layer[k-1].o_zero;
      assign i_tag   = g_layer[k-1].o_tag;
`ifdef FPU_LZD_NORM_EN
      assign i_data  = g_layer[k-1].o_data;
`endif
    end

    if (IS_REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          o_valid <= 1'b0;
          o_val   <= '0;
          o_pos   <= '0;
          o_zero  <= 1'b0;
          o_tag   <= '0;
`ifdef FPU_LZD_NORM_EN
          o_data  <= '0;
`endif
        end else if (!stall) begin
          o_valid <= i_valid;
          if (i_valid) begin
            o_val  <= c_val;
            o_pos  <= c_pos;
            o_zero <= i_zero;
            o_tag  <= i_tag;
`ifdef FPU_LZD_NORM_EN
            o_data <= i_data;
`endif
          end
        end
      end
    end else begin : g_wire
      assign o_valid = i_valid;
      assign o_val   = c_val;
      assign o_pos   = c_pos;
      assign o_zero  = i_zero;
      assign o_tag   = i_tag;
`ifdef FPU_LZD_NORM_EN
      assign o_data  = i_data;
`endif
    end
  end

  logic              root_val;
  logic [LAYERS-1:0] root_pos;
  logic              f_valid, f_zero;
  logic [TAG_W-1:0]  f_tag;

  // A clear root val can only come from an all-zero word, so it folds into the zero flag.
  assign root_val = g_layer[LAYERS-1].o_val[0];
  assign root_pos = g_layer[LAYERS-1].o_pos;
  assign f_valid  = g_layer[LAYERS-1].o_valid;
  assign f_zero   = g_layer[LAYERS-1].o_zero | ~root_val;
  assign f_tag    = g_layer[LAYERS-1].o_tag;

`ifdef FPU_LZD_NORM_EN
  logic [WIDTH-1:0] f_data;
  assign f_data = g_layer[LAYERS-1].o_data;
`else
  assign out_norm = '0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
`ifdef FPU_LZD_NORM_EN
      out_norm  <= '0;
`endif
    end else if (!stall) begin
      out_valid <= f_valid;
      if (f_valid) begin
        out_cnt  <= f_zero ? CNT_W'(WIDTH) : CNT_W'(root_pos);
        out_zero <= f_zero;
        out_tag  <= f_tag;
`ifdef FPU_LZD_NORM_EN
        out_norm <= f_zero ? '0 : (f_data << root_pos);
`endif
      end
    end
  end

endmodule

// File: tb/tb_fpu_lzd_pipe.sv
// Self-checking bench for fpu_lzd_pipe: a 24-bit/REG_EVERY=2 instance under directed, stalled and reset traffic,
// and an 8-bit/REG_EVERY=1 instance swept over every input value.
module tb_fpu_lzd_pipe;
  localparam int W    = 24;
  localparam int TW   = 4;
  localparam int CW   = 5;
  localparam int LAT  = 3;
  localparam int W8   = 8;
  localparam int CW8  = 4;
  localparam int LAT8 = 3;
`ifdef FPU_LZD_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [63:0] tag;
    int          acc;
    int          stalls;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_l = 1'b1;

  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_zero;
  logic [W-1:0]  in_data = '0, out_norm;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [CW-1:0] out_cnt;

  logic          in_valid8 = 1'b0, in_ready8, out_valid8, out_zero8;
  logic [W8-1:0] in_data8 = '0, out_norm8;
  logic [TW-1:0] in_tag8 = '0, out_tag8;
  logic [CW8-1:0] out_cnt8;

  fpu_lzd_pipe #(.WIDTH(W), .REG_EVERY(2), .TAG_W(TW)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag)
  );

  fpu_lzd_pipe #(.WIDTH(W8), .REG_EVERY(1), .TAG_W(TW)) dut8 (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_cnt(out_cnt8),
    .out_zero(out_zero8), .out_norm(out_norm8), .out_tag(out_tag8)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference count: scan from the MSB down to the first one.
  function automatic int ref_lzc(input logic [63:0] d, input int w);
    for (int i = w - 1; i >= 0; i--)
      if (d[i]) return w - 1 - i;
    return w;
  endfunction

  item_t         q[$], q8[$];
  item_t         e, e8;
  int            c, c8, stalls = 0, n8 = 0;
  logic          held = 1'b0, exp_rdy, stream_done;
  logic [W-1:0]  en, rnd;
  logic [W8-1:0] en8;

  always @(negedge clk) begin
    if (!rst_l) begin
      q.delete();
      held = 1'b0;
    end else begin
      exp_rdy = !(out_valid && !out_ready);
      check_output("in_ready_rule", in_ready, exp_rdy);
      if (out_valid) begin
        if (q.size() == 0) check_output("spurious_valid", out_valid, 1'b0);
        else begin
          e  = q[0];
          c  = ref_lzc(e.data, W);
          en = (NORM && c < W) ? W'(e.data << c) : '0;
          check_output("cnt", out_cnt, 64'(c));
          check_output("zero", out_zero, 64'(c == W));
          check_output("tag", out_tag, e.tag);
          check_output("norm", out_norm, en);
          if (!held) check_output("latency", 64'(cyc), 64'(e.acc + LAT + stalls - e.stalls));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e.data = 64'(in_data); e.tag = 64'(in_tag); e.acc = cyc; e.stalls = stalls;
        q.push_back(e);
      end
      held = out_valid && !out_ready;
      if (held) stalls++;
    end
  end

  always @(negedge clk) begin
    if (!rst_l) q8.delete();
    else begin
      if (out_valid8) begin
        if (q8.size() == 0) check_output("spurious_valid8", out_valid8, 1'b0);
        else begin
          e8  = q8[0];
          c8  = ref_lzc(e8.data, W8);
          en8 = (NORM && c8 < W8) ? W8'(e8.data << c8) : '0;
          check_output("cnt8", out_cnt8, 64'(c8));
          check_output("zero8", out_zero8, 64'(c8 == W8));
          check_output("tag8", out_tag8, e8.tag);
          check_output("norm8", out_norm8, en8);
          check_output("latency8", 64'(cyc), 64'(e8.acc + LAT8));
          case (e8.data[7:0])
            8'h00:   check_output("pin8_00", out_cnt8, 8);
            8'h01:   check_output("pin8_01", out_cnt8, 7);
            8'h80:   check_output("pin8_80", out_cnt8, 0);
            default: ;
          endcase
          void'(q8.pop_front());
          n8++;
        end
      end
      if (in_valid8 && in_ready8) begin
        e8.data = 64'(in_data8); e8.tag = 64'(in_tag8); e8.acc = cyc; e8.stalls = 0;
        q8.push_back(e8);
      end
    end
  end

  // Caller must be at posedge+1; returns at posedge+1 after the word is taken.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic [TW-1:0] t);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_tag = t;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    check_output("accept", ok, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
    check_output("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2 rst_l = 1'b0;
    #1;
    check_output("rst_valid", out_valid, 0);
    check_output("rst_ready", in_ready, 1);
    check_output("rst_cnt", out_cnt, 0);
    check_output("rst_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(24'h800000, 4'h1);
    apply_stimulus(24'h000001, 4'h2);
    apply_stimulus(24'h0F0000, 4'h3);
    @(negedge clk);
    check_output("t1_valid0", out_valid, 1);
    check_output("t1_cnt0", out_cnt, 0);
    check_output("t1_tag0", out_tag, 4'h1);
    check_output("t1_norm0", out_norm, NORM ? 24'h800000 : 24'h0);
    @(negedge clk);
    check_output("t1_cnt1", out_cnt, 23);
    check_output("t1_tag1", out_tag, 4'h2);
    check_output("t1_norm1", out_norm, NORM ? 24'h800000 : 24'h0);
    @(negedge clk);
    check_output("t1_cnt2", out_cnt, 4);
    check_output("t1_zero2", out_zero, 0);
    check_output("t1_norm2", out_norm, NORM ? 24'hF00000 : 24'h0);
    @(posedge clk); #1;

    apply_stimulus(24'h000000, 4'h4);
    apply_stimulus(24'h000100, 4'h5);
    @(negedge clk);
    @(negedge clk);
    check_output("zero_cnt", out_cnt, 24);
    check_output("zero_flag", out_zero, 1);
    check_output("zero_norm", out_norm, 0);
    @(negedge clk);
    check_output("w100_cnt", out_cnt, 15);
    check_output("w100_norm", out_norm, NORM ? 24'h800000 : 24'h0);
    drain();

    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rnd = 24'($urandom) >> $urandom_range(0, 24);
          apply_stimulus(rnd, TW'(i + 6));
        end
        stream_done = 1'b1;
      end
      begin
        for (int k = 0; k < 300 && !stream_done; k++) begin
          @(posedge clk); #1;
          if (k % 2 == 1) out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    apply_stimulus(24'h000010, 4'hA);
    apply_stimulus(24'h000020, 4'hB);
    apply_stimulus(24'h000040, 4'hC);
    apply_stimulus(24'h000080, 4'hD);
    check_output("pre_rst_valid", out_valid, 1);
    #2 rst_l = 1'b0;
    #1;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_ready", in_ready, 1);
    check_output("mid_rst_cnt", out_cnt, 0);
    check_output("mid_rst_zero", out_zero, 0);
    check_output("mid_rst_tag", out_tag, 0);
    check_output("mid_rst_norm", out_norm, 0);
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_output("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    apply_stimulus(24'h004000, 4'h7);
    @(negedge clk);
    check_output("post_rst_wait0", out_valid, 0);
    @(negedge clk);
    check_output("post_rst_wait1", out_valid, 0);
    @(negedge clk);
    check_output("post_rst_valid", out_valid, 1);
    check_output("post_rst_cnt", out_cnt, 9);
    drain();

    in_valid8 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      in_data8 = 8'(v);
      in_tag8  = 4'(v);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    for (int n = 0; n < 20 && q8.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check_output("sweep8_empty", q8.size(), 0);
    check_output("sweep8_count", n8, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
